// File: rtl/fetch_if.sv
// Instruction-bus types and the request/response interface between fetch and the instruction memory.
// The package also carries the F/D slot type shared with decode.
package fetch_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

interface fetch_if;
  import fetch_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;

  modport master (output ireq, input iresp);
  modport slave  (input ireq, output iresp);
endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding bus request, a registered F/D slot and a one-word
// skid buffer so a response arriving while decode stalls is never lost.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  fetch_if.master     ibus,
  input  logic        branch,
  input  logic [63:0] PCbranch,
  input  logic        stallF,
  output fetch_data_t dataF
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_DROP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic [63:0] redirect_pc_reg, redirect_pc_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  fetch_data_t dataf_reg, dataf_next;

  logic        data_ok;
  logic [31:0] data;
  logic        accept;
  logic        redirect;
  logic        req_valid;
  logic        unused_addr_ok;

  assign data_ok        = ibus.iresp.data_ok;
  assign data           = ibus.iresp.data;
  assign unused_addr_ok = ibus.iresp.addr_ok;

  assign accept   = dataf_reg.valid && !stallF;
  assign redirect = accept && branch;

  // The request drops combinationally with reset so an abandoned transaction is not re-presented.
  assign req_valid = !reset && (state_reg != ST_HOLD);
  assign ibus.ireq = '{valid: req_valid, addr: pc_reg};
  assign dataF     = dataf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_REQ;
      pc_reg          <= PCINIT;
      redirect_pc_reg <= '0;
      buf_instr_reg   <= '0;
      dataf_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      redirect_pc_reg <= redirect_pc_next;
      buf_instr_reg   <= buf_instr_next;
      dataf_reg       <= dataf_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    redirect_pc_next = redirect_pc_reg;
    buf_instr_next   = buf_instr_reg;
    dataf_next       = dataf_reg;

    case (state_reg)
      ST_REQ: begin
        if (redirect) begin
          dataf_next.valid = 1'b0;
          if (data_ok) begin
            pc_next = PCbranch;
          end else begin
            // The in-flight address must stay on the bus until its response is swallowed.
            redirect_pc_next = PCbranch;
            state_next       = ST_DROP;
          end
        end else if (data_ok) begin
          if (!dataf_reg.valid || accept) begin
            dataf_next = '{valid: 1'b1, pc: pc_reg, raw_instr: data};
            pc_next    = pc_reg + 64'd4;
          end else begin
            buf_instr_next = data;
            state_next     = ST_HOLD;
          end
        end else if (accept) begin
          dataf_next.valid = 1'b0;
        end
      end

      ST_DROP: begin
        dataf_next.valid = 1'b0;
        if (data_ok) begin
          pc_next    = redirect_pc_reg;
          state_next = ST_REQ;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          dataf_next.valid = 1'b0;
          pc_next          = PCbranch;
          state_next       = ST_REQ;
        end else if (accept) begin
          // pc still names the buffered word; it was not advanced when the word was parked.
          dataf_next = '{valid: 1'b1, pc: pc_reg, raw_instr: buf_instr_reg};
          pc_next    = pc_reg + 64'd4;
          state_next = ST_REQ;
        end
      end

      default: begin
        state_next = ST_REQ;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch.sv
// Randomised bench for fetch: a variable-latency memory model plus a transaction-level model of
// the expected instruction stream (next pc to deliver, redirect targets, stall/skid behaviour).
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [63:0] PCINIT = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch;
  logic [63:0] pcbranch;
  logic        stallf;
  fetch_data_t dataf;

  fetch_if bus ();

  fetch #(.PCINIT(PCINIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .ibus     (bus.master),
    .branch   (branch),
    .PCbranch (pcbranch),
    .stallF   (stallf),
    .dataF    (dataf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [63:0] exp_pc;
  logic        outstanding;
  logic [63:0] out_addr;
  int          wait_cnt;
  logic        buffered;
  logic        snap_valid;
  fetch_data_t snap;
  logic        exp_valid1;
  logic        exp_valid0;
  logic        exp_addr_chk;
  logic [63:0] exp_addr;
  int          cyc;

  // Stimulus knobs
  int          lat_lo, lat_hi, stall_pct, br_pct;
  logic        tput_chk;
  logic        force_br;
  logic [63:0] force_tgt;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_2468;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    case ($urandom_range(3, 0))
      0: t = {$urandom, $urandom};
      1: t = 64'hFFFF_FFFF_FFFF_FFF8;
      2: t = 64'h8000_0100;
      default: t = {32'h0000_0000, $urandom} & ~64'd3;
    endcase
    return t;
  endfunction

  // Called at a negedge: check outputs settled from the last edge, drive inputs, advance the model.
  task automatic step();
    logic acc, dok;
    if (snap_valid)   check_val("stall_hold", dataf, snap);
    if (exp_valid1)   check_val("buf_release_valid", dataf.valid, 1'b1);
    if (exp_valid0)   check_val("redirect_kill_valid", dataf.valid, 1'b0);
    if (exp_addr_chk) check_val("redirect_addr", bus.ireq.addr, exp_addr);
    if (buffered)     check_val("hold_ireq_idle", bus.ireq.valid, 1'b0);
    if (tput_chk && cyc >= 1) check_val("tput_valid", dataf.valid, 1'b1);
    if (bus.ireq.valid && outstanding) check_val("addr_stable", bus.ireq.addr, out_addr);
    if (bus.ireq.valid && !outstanding) begin
      outstanding = 1'b1;
      out_addr    = bus.ireq.addr;
      wait_cnt    = $urandom_range(lat_hi, lat_lo);
    end

    stallf   = ($urandom_range(99, 0) < stall_pct);
    branch   = force_br || ($urandom_range(99, 0) < br_pct);
    pcbranch = force_br ? force_tgt : pick_target();
    dok      = bus.ireq.valid && (wait_cnt == 0);
    bus.iresp.data_ok = dok;
    bus.iresp.data    = dok ? mem_word(bus.ireq.addr) : $urandom;
    bus.iresp.addr_ok = 1'($urandom);

    acc          = dataf.valid && !stallf;
    snap_valid   = dataf.valid && stallf;
    snap         = dataf;
    exp_valid1   = 1'b0;
    exp_valid0   = 1'b0;
    exp_addr_chk = 1'b0;
    if (acc) begin
      check_val("deliver_pc", dataf.pc, exp_pc);
      check_val("deliver_instr", dataf.raw_instr, mem_word(exp_pc));
      if (branch) begin
        exp_pc     = pcbranch;
        exp_valid0 = 1'b1;
        force_br   = 1'b0;
        if (dok) begin
          exp_addr_chk = 1'b1;
          exp_addr     = pcbranch;
        end
      end else begin
        exp_pc = exp_pc + 64'd4;
        if (buffered) exp_valid1 = 1'b1;
      end
      buffered = 1'b0;
    end
    if (dok) begin
      if (dataf.valid && stallf) buffered = 1'b1;
      outstanding = 1'b0;
    end else if (outstanding) begin
      wait_cnt--;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset             = 1'b1;
    stallf            = 1'($urandom);
    branch            = 1'($urandom);
    pcbranch          = {$urandom, $urandom};
    bus.iresp.data_ok = 1'($urandom);
    bus.iresp.data    = $urandom;
    bus.iresp.addr_ok = 1'($urandom);
    #1;
    check_val("rst_ireq_idle", bus.ireq.valid, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("rst_dataf", dataf, '0);
      check_val("rst_ireq_idle_hold", bus.ireq.valid, 1'b0);
    end
    reset = 1'b0;
    exp_pc = PCINIT; outstanding = 1'b0; wait_cnt = 0; buffered = 1'b0;
    snap_valid = 1'b0; exp_valid1 = 1'b0; exp_valid0 = 1'b0; exp_addr_chk = 1'b0;
    force_br = 1'b0; cyc = 0;
    #1;
    check_val("first_req_valid", bus.ireq.valid, 1'b1);
    check_val("first_req_addr", bus.ireq.addr, PCINIT);
  endtask

  task automatic set_knobs(input int lo, input int hi, input int st, input int br);
    lat_lo = lo; lat_hi = hi; stall_pct = st; br_pct = br;
  endtask

  task automatic wait_dataf_valid(input string tag);
    int k;
    k = 0;
    while (!dataf.valid && k < 30) begin
      step();
      k++;
    end
    check_val(tag, dataf.valid, 1'b1);
  endtask

  initial begin
    tput_chk = 1'b0;
    force_br = 1'b0;
    force_tgt = '0;
    set_knobs(0, 0, 0, 0);
    @(negedge clk);
    do_reset(3);

    // Zero-latency bus, no stalls: one instruction per cycle.
    tput_chk = 1'b1;
    repeat (30) step();
    tput_chk = 1'b0;

    // Two-cycle latency bus.
    set_knobs(1, 1, 0, 0);
    repeat (30) step();

    // Stalls with short latencies exercise the skid buffer.
    set_knobs(0, 2, 40, 0);
    repeat (300) step();

    // Branch issued while a 3-cycle request is in flight.
    set_knobs(2, 2, 0, 0);
    wait_dataf_valid("wait_valid_drop");
    force_br = 1'b1; force_tgt = 64'h8000_0100;
    repeat (12) step();

    // Branch coinciding with data_ok on a zero-latency bus.
    set_knobs(0, 0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      wait_dataf_valid("wait_valid_coincide");
      force_br = 1'b1; force_tgt = 64'h8000_0040;
      repeat (4) step();
    end

    // Fully random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      set_knobs(0, $urandom_range(3, 0), $urandom_range(50, 0), $urandom_range(30, 0));
      if ($urandom_range(299, 0) == 0) do_reset($urandom_range(3, 1));
      else step();
    end

    // Reset while a redirect is waiting for its in-flight response.
    set_knobs(2, 2, 0, 0);
    wait_dataf_valid("wait_valid_rst_drop");
    force_br = 1'b1; force_tgt = 64'h8000_0100;
    step();
    check_val("drop_addr_held", bus.ireq.addr, out_addr);
    do_reset(1);
    set_knobs(0, 0, 0, 0);
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
